// File: rtl/checkpoint_seq_monitor.sv
// checkpoint_seq_monitor: programmable masked checkpoint sequence checker
// with glitch filter, per-step timeout and optional strict ordering.
module checkpoint_seq_monitor #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int TW     = 20,
  parameter int STABLE = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tbl_we,
  input  logic [AW-1:0]    tbl_addr,
  input  logic [WIDTH-1:0] tbl_value,
  input  logic [WIDTH-1:0] tbl_mask,
  input  logic [AW:0]      seq_len,
  input  logic [TW-1:0]    step_timeout,
  input  logic             strict,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] checkbits,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [AW-1:0]    step_idx,
  output logic             step_hit,
  output logic [AW-1:0]    hit_idx,
  output logic [TW-1:0]    cyc_count
);

  localparam int RW   = $clog2(STABLE + 2);
  localparam int STP1 = STABLE + 1;
  localparam logic [RW-1:0] L_STB  = STABLE[RW-1:0];
  localparam logic [RW-1:0] L_STB1 = STP1[RW-1:0];
  localparam logic [RW-1:0] L_R1   = {{(RW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   L_DEP  = DEPTH[AW:0];
  localparam logic [AW:0]   L_L1   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] L_S1   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] L_T1   = {{(TW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_PASS,
    S_FAIL
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_val [DEPTH];
  logic [WIDTH-1:0] r_msk [DEPTH];
  logic [WIDTH-1:0] r_cb;
  logic [WIDTH-1:0] r_settled;
  logic [RW-1:0]    r_run;
  logic             r_fresh;
  logic [AW:0]      r_len;
  logic [TW-1:0]    r_tmo;
  logic             r_strict;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;
  logic [1:0]       r_code;
  logic [AW-1:0]    r_step;
  logic             r_hit;
  logic [AW-1:0]    r_hit_idx;
  logic [TW-1:0]    r_cyc;

  logic w_cur;
  logic w_ooo;
  logic w_last;
  logic w_tmo;
  logic w_cfg_bad;

  function automatic logic f_match(
    input logic [WIDTH-1:0] s,
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] m
  );
    return ((s ^ v) & m) == '0;
  endfunction

  // Table storage; frozen while a sequence is armed.
  always_ff @(posedge clock) begin
    if (tbl_we && !r_busy) begin
      r_val[tbl_addr] <= tbl_value;
      r_msk[tbl_addr] <= tbl_mask;
    end
  end

  // Input register plus run-length filter; emits one pulse per settle event.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cb      <= '0;
      r_run     <= '0;
      r_fresh   <= 1'b0;
      r_settled <= '0;
    end else begin
      r_fresh <= (r_run == L_STB);
      if (r_run == L_STB) r_settled <= r_cb;
      if (checkbits != r_cb) begin
        r_cb  <= checkbits;
        r_run <= L_R1;
      end else if (r_run != L_STB1) begin
        r_run <= r_run + L_R1;
      end
    end
  end

  // Match against the current step and scan later steps for strict mode.
  always_comb begin
    w_cur = r_fresh &&
            f_match(r_settled, r_val[r_step], r_msk[r_step]);
    w_ooo = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if ((j > int'(r_step)) && (j < int'(r_len)) &&
          f_match(r_settled, r_val[j], r_msk[j]))
        w_ooo = 1'b1;
    end
    w_ooo     = w_ooo && r_fresh && r_strict && !w_cur;
    w_last    = ({1'b0, r_step} == (r_len - L_L1));
    w_tmo     = (r_tmo != '0) && (r_cyc == (r_tmo - L_T1));
    w_cfg_bad = (seq_len == '0) || (seq_len > L_DEP);
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clock) begin
    if (reset || abort) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_tmo     <= '0;
      r_strict  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_code    <= 2'd0;
      r_step    <= '0;
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
      r_cyc     <= '0;
    end else begin
      r_hit <= 1'b0;
      unique case (r_state)
        S_IDLE, S_PASS, S_FAIL: begin
          if (start) begin
            r_len    <= seq_len;
            r_tmo    <= step_timeout;
            r_strict <= strict;
            r_step   <= '0;
            r_cyc    <= '0;
            r_pass   <= 1'b0;
            if (w_cfg_bad) begin
              r_state <= S_FAIL;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_fail  <= 1'b1;
              r_code  <= 2'd3;
            end else begin
              r_state <= S_ARMED;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_fail  <= 1'b0;
              r_code  <= 2'd0;
            end
          end
        end
        S_ARMED: begin
          if (w_cur) begin
            r_hit     <= 1'b1;
            r_hit_idx <= r_step;
            r_cyc     <= '0;
            if (w_last) begin
              r_state <= S_PASS;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_step <= r_step + L_S1;
            end
          end else if (w_ooo || w_tmo) begin
            r_state <= S_FAIL;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_fail  <= 1'b1;
            r_code  <= w_ooo ? 2'd2 : 2'd1;
          end else if (r_cyc != '1) begin
            r_cyc <= r_cyc + L_T1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign fail_code = r_code;
  assign step_idx  = r_step;
  assign step_hit  = r_hit;
  assign hit_idx   = r_hit_idx;
  assign cyc_count = r_cyc;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// tb_checkpoint_seq_monitor: directed bench with a hit scoreboard
// for checkpoint_seq_monitor (WIDTH 16, DEPTH 8, STABLE 2).
module tb_checkpoint_seq_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic        tbl_we;
  logic [2:0]  tbl_addr;
  logic [15:0] tbl_value;
  logic [15:0] tbl_mask;
  logic [3:0]  seq_len;
  logic [19:0] step_timeout;
  logic        strict;
  logic        start;
  logic        abort;
  logic [15:0] checkbits;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail;
  logic [1:0]  fail_code;
  logic [2:0]  step_idx;
  logic        step_hit;
  logic [2:0]  hit_idx;
  logic [19:0] cyc_count;

  checkpoint_seq_monitor dut (
    .clock        (clock),
    .reset        (reset),
    .tbl_we       (tbl_we),
    .tbl_addr     (tbl_addr),
    .tbl_value    (tbl_value),
    .tbl_mask     (tbl_mask),
    .seq_len      (seq_len),
    .step_timeout (step_timeout),
    .strict       (strict),
    .start        (start),
    .abort        (abort),
    .checkbits    (checkbits),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .fail_code    (fail_code),
    .step_idx     (step_idx),
    .step_hit     (step_hit),
    .hit_idx      (hit_idx),
    .cyc_count    (cyc_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every step_hit pops the oldest expected hit.
  always @(negedge clock) begin
    if (step_hit === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL hit_unexpected: observed idx %0d at cyc %0d expected none",
                 hit_idx, cyc);
        end
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hit_idx", 64'(hit_idx), 64'(e.idx));
        chk("hit_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [15:0] v,
                    input logic [15:0] m);
    tbl_we    = 1'b1;
    tbl_addr  = a;
    tbl_value = v;
    tbl_mask  = m;
    tick(1);
    tbl_we    = 1'b0;
  endtask

  task automatic go(input logic [3:0] len,
                    input logic [19:0] tmo,
                    input logic s);
    seq_len      = len;
    step_timeout = tmo;
    strict       = s;
    start        = 1'b1;
    tick(1);
    start        = 1'b0;
  endtask

  // Change checkbits; a steady value hits 4 negedges later.
  task automatic drive(input logic [15:0] v, input int idx);
    checkbits = v;
    if (idx >= 0) exp_q.push_back('{idx, cyc + 4});
  endtask

  task automatic quiet();
    checkbits = 16'h0000;
    tick(5);
  endtask

  task automatic std_table();
    wr(3'd0, 16'hAB40, 16'hFFFF);
    wr(3'd1, 16'hAB41, 16'hFFFF);
    wr(3'd2, 16'hAB51, 16'hFFFF);
  endtask

  task automatic run_s1(input string tag);
    quiet();
    go(4'd3, 20'd1000, 1'b0);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    drive(16'hAB40, 0); tick(10);
    drive(16'hAB41, 1); tick(10);
    drive(16'hAB51, 2); tick(10);
    chk({tag, "_pass"}, 64'({done, pass, fail, busy}), 64'b1100);
  endtask

  logic [32:0] all_out;
  assign all_out = {busy, done, pass, fail, fail_code,
                    step_idx, step_hit, hit_idx, cyc_count};

  initial begin
    reset = 1'b1; tbl_we = 1'b0; tbl_addr = '0;
    tbl_value = '0; tbl_mask = '0; seq_len = '0;
    step_timeout = '0; strict = 1'b0; start = 1'b0;
    abort = 1'b0; checkbits = '0;
    tick(3);
    chk("reset_outs", 64'(all_out), 64'd0);
    reset = 1'b0;
    tick(1);
    std_table();

    // 1: in-order sequence
    run_s1("s1");

    // 2: timeout on step 1, exact boundary
    quiet();
    go(4'd3, 20'd1000, 1'b0);
    drive(16'hAB40, 0);
    tick(4);
    tick(999);
    chk("s2_pre_fail", 64'(fail), 64'd0);
    chk("s2_pre_cyc", 64'(cyc_count), 64'd999);
    tick(1);
    chk("s2_fail", 64'({done, fail, fail_code}), 64'b1101);
    chk("s2_step", 64'(step_idx), 64'd1);
    chk("s2_cyc", 64'(cyc_count), 64'd999);

    // 3: strict out-of-order, then non-strict same stimulus
    quiet();
    go(4'd3, 20'd1000, 1'b1);
    drive(16'hAB40, 0); tick(10);
    drive(16'hAB51, -1); tick(10);
    chk("s3_code", 64'({fail, fail_code}), 64'b110);
    chk("s3_step", 64'(step_idx), 64'd1);
    quiet();
    go(4'd3, 20'd1000, 1'b0);
    drive(16'hAB40, 0); tick(10);
    drive(16'hAB51, -1); tick(10);
    chk("s3_lax", 64'({busy, fail, step_idx}), 64'b10001);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("s3_abort", 64'({busy, done, fail, fail_code}), 64'd0);

    // 4: one-cycle glitch filtered, two-cycle pulse accepted
    quiet();
    go(4'd3, 20'd1000, 1'b0);
    drive(16'hAB40, 0); tick(10);
    drive(16'hAB41, -1); tick(1);
    drive(16'hAB51, -1); tick(10);
    chk("s4_glitch", 64'({busy, step_idx}), 64'b1001);
    abort = 1'b1; tick(1); abort = 1'b0;
    quiet();
    go(4'd3, 20'd1000, 1'b0);
    drive(16'hAB40, 0); tick(10);
    drive(16'hAB41, 1); tick(2);
    drive(16'hAB51, 2); tick(10);
    chk("s4_pulse", 64'({done, pass}), 64'b11);

    // 5: masked compare and configuration errors
    wr(3'd0, 16'hAB00, 16'hFF00);
    quiet();
    go(4'd1, 20'd1000, 1'b0);
    drive(16'hAB7F, 0); tick(10);
    chk("s5_mask", 64'({done, pass, fail}), 64'b110);
    wr(3'd0, 16'hAB40, 16'hFFFF);
    go(4'd0, 20'd1000, 1'b0);
    chk("s5_len0", 64'({busy, done, fail, fail_code}), 64'b01111);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("s5_clear", 64'({done, fail, fail_code}), 64'd0);
    go(4'd9, 20'd1000, 1'b0);
    chk("s5_len9", 64'({busy, done, fail, fail_code}), 64'b01111);

    // 6: reset mid-step, abort beats start, write while busy ignored
    quiet();
    go(4'd3, 20'd1000, 1'b0);
    drive(16'hAB40, 0); tick(10);
    reset = 1'b1; tick(1);
    chk("s6_reset", 64'(all_out), 64'd0);
    reset = 1'b0; tick(1);
    abort = 1'b1; start = 1'b1; seq_len = 4'd3;
    tick(1);
    abort = 1'b0; start = 1'b0;
    chk("s6_abort_start", 64'({busy, done}), 64'd0);
    quiet();
    go(4'd3, 20'd1000, 1'b0);
    wr(3'd1, 16'h1234, 16'hFFFF);
    abort = 1'b1; tick(1); abort = 1'b0;
    run_s1("s6_rerun");

    tick(5);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
